// File: rtl/rf_port_sequencer.sv
// rf_port_sequencer: owns the single write port of the decode-stage register
// file. Clears x1..x31 after reset, then merges W-stage writes with debug
// read/write requests, W-stage first, with a bounded wait for debug writes.
module rf_port_sequencer #(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            dbg_req,
    input  logic            dbg_we,
    input  logic [4:0]      dbg_addr,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic            dbg_ack,
    output logic [XLEN-1:0] dbg_rdata,
    output logic [4:0]      rf_dbg_raddr,
    input  logic [XLEN-1:0] rf_dbg_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            stall_o,
    output logic            init_done
);

    localparam logic [4:0] LAST_IDX   = 5'(NUM_REGS - 1);
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WAIT,
        ST_FORCE,
        ST_ACK
    } state_e;

    state_e            state_q, state_d;
    logic [4:0]        clr_idx_q, clr_idx_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [XLEN-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic              dbg_ack_q;
    logic              init_done_q;
    logic              wb_valid;

    // Writes to x0 are architecturally meaningless, so they never claim the port.
    assign wb_valid     = wb_we && (wb_rd != 5'd0);
    assign rf_dbg_raddr = dbg_addr;
    assign dbg_ack      = dbg_ack_q;
    assign dbg_rdata    = dbg_rdata_q;
    assign init_done    = init_done_q;

    // State register plus registered debug response and init flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clr_idx_q   <= 5'd1;
            wait_cnt_q  <= 4'd0;
            dbg_rdata_q <= '0;
            dbg_ack_q   <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            wait_cnt_q  <= wait_cnt_d;
            dbg_rdata_q <= dbg_rdata_d;
            // The ack pulse is exactly the cycle spent in ACK.
            dbg_ack_q   <= (state_d == ST_ACK);
            init_done_q <= init_done_q || ((state_q == ST_CLEAR) && (clr_idx_q == LAST_IDX));
        end
    end

    // Next-state and write-port mux; W stage owns the port unless overridden.
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        wait_cnt_d  = wait_cnt_q;
        dbg_rdata_d = dbg_rdata_q;
        rf_we       = wb_valid;
        rf_waddr    = wb_rd;
        rf_wdata    = wb_data;
        stall_o     = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                stall_o   = 1'b1;
                rf_we     = 1'b1;
                rf_waddr  = clr_idx_q;
                rf_wdata  = '0;
                clr_idx_d = clr_idx_q + 5'd1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE, ST_WAIT: begin
                if (dbg_req) begin
                    if (!dbg_we) begin
                        // Bypass the W-stage result so a read never returns stale data.
                        if (dbg_addr == 5'd0) begin
                            dbg_rdata_d = '0;
                        end else if (wb_valid && (wb_rd == dbg_addr)) begin
                            dbg_rdata_d = wb_data;
                        end else begin
                            dbg_rdata_d = rf_dbg_rdata;
                        end
                        wait_cnt_d = 4'd0;
                        state_d    = ST_ACK;
                    end else if (dbg_addr == 5'd0) begin
                        // Nothing to write; complete without touching the port.
                        wait_cnt_d = 4'd0;
                        state_d    = ST_ACK;
                    end else if (!wb_valid) begin
                        rf_we      = 1'b1;
                        rf_waddr   = dbg_addr;
                        rf_wdata   = dbg_wdata;
                        wait_cnt_d = 4'd0;
                        state_d    = ST_ACK;
                    end else if ((state_q == ST_WAIT) && (wait_cnt_q >= MAX_WAIT_C)) begin
                        state_d = ST_FORCE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                        state_d    = ST_WAIT;
                    end
                end else begin
                    // Request withdrawn while waiting: abandon it quietly.
                    wait_cnt_d = 4'd0;
                    state_d    = ST_IDLE;
                end
            end
            ST_FORCE: begin
                // Freezing the pipeline keeps the dropped W write on its inputs,
                // so it is replayed in the following cycle.
                stall_o    = 1'b1;
                rf_we      = 1'b1;
                rf_waddr   = dbg_addr;
                rf_wdata   = dbg_wdata;
                wait_cnt_d = 4'd0;
                state_d    = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

endmodule

// File: tb/tb_rf_port_sequencer.sv
// Directed bench for rf_port_sequencer with a behavioural register file.
module tb_rf_port_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        dbg_req;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic [4:0]  rf_dbg_raddr;
    logic [31:0] rf_dbg_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_o;
    logic        init_done;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int stall_cycles;

    logic [31:0] rf_mem [32];

    always #5 clk = ~clk;

    rf_port_sequencer #(.NUM_REGS(32), .XLEN(32), .MAX_WAIT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .dbg_req      (dbg_req),
        .dbg_we       (dbg_we),
        .dbg_addr     (dbg_addr),
        .dbg_wdata    (dbg_wdata),
        .dbg_ack      (dbg_ack),
        .dbg_rdata    (dbg_rdata),
        .rf_dbg_raddr (rf_dbg_raddr),
        .rf_dbg_rdata (rf_dbg_rdata),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .stall_o      (stall_o),
        .init_done    (init_done)
    );

    // Register file model; x0 returns garbage so the sequencer must zero it itself.
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    end
    assign rf_dbg_rdata = (rf_dbg_raddr == 5'd0) ? 32'hBAD0_BAD0 : rf_mem[rf_dbg_raddr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to the next negedge and settle; inputs are driven right after.
    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'h5555_5555;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ack", {31'd0, dbg_ack}, 32'd0);
        chk("rst_rdata", dbg_rdata, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);

        // Clear sequence with a debug request held throughout.
        stall_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            dbg_req = (i < 31);
            #1;
            if (stall_o && rf_we) stall_cycles++;
            chk("clr_ack", {31'd0, dbg_ack}, 32'd0);
            if (i < 31) begin
                chk("clr_stall", {31'd0, stall_o}, 32'd1);
                chk("clr_we", {31'd0, rf_we}, 32'd1);
                chk("clr_waddr", {27'd0, rf_waddr}, 32'(i + 1));
                chk("clr_wdata", rf_wdata, 32'd0);
                chk("clr_init_done", {31'd0, init_done}, 32'd0);
            end else begin
                chk("post_stall", {31'd0, stall_o}, 32'd0);
                chk("post_we", {31'd0, rf_we}, 32'd0);
                chk("post_init_done", {31'd0, init_done}, 32'd1);
            end
        end
        chk("clr_cycles", 32'(stall_cycles), 32'd31);

        // Unblocked debug write x5.
        next_cyc();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'hDEAD_BEEF;
        #1;
        chk("w5_we", {31'd0, rf_we}, 32'd1);
        chk("w5_waddr", {27'd0, rf_waddr}, 32'd5);
        chk("w5_wdata", rf_wdata, 32'hDEAD_BEEF);
        chk("w5_stall", {31'd0, stall_o}, 32'd0);
        chk("w5_noack", {31'd0, dbg_ack}, 32'd0);
        next_cyc();
        dbg_req = 1'b0;
        #1;
        chk("w5_ack", {31'd0, dbg_ack}, 32'd1);
        next_cyc();
        chk("w5_ack_pulse", {31'd0, dbg_ack}, 32'd0);

        // Blocked debug write x7 against continuous W writes to x3.
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_A5A5;
        dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h0000_0011;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) next_cyc();
            dbg_req = (c <= 10);
            #1;
            if (c <= 9) begin
                chk("blk_waddr", {27'd0, rf_waddr}, 32'd3);
                chk("blk_stall", {31'd0, stall_o}, 32'd0);
                chk("blk_ack", {31'd0, dbg_ack}, 32'd0);
            end else if (c == 10) begin
                chk("force_stall", {31'd0, stall_o}, 32'd1);
                chk("force_we", {31'd0, rf_we}, 32'd1);
                chk("force_waddr", {27'd0, rf_waddr}, 32'd7);
                chk("force_wdata", rf_wdata, 32'h0000_0011);
                chk("force_ack", {31'd0, dbg_ack}, 32'd0);
            end else if (c == 11) begin
                chk("replay_waddr", {27'd0, rf_waddr}, 32'd3);
                chk("replay_wdata", rf_wdata, 32'h0000_A5A5);
                chk("replay_stall", {31'd0, stall_o}, 32'd0);
                chk("replay_ack", {31'd0, dbg_ack}, 32'd1);
            end else begin
                chk("tail_ack", {31'd0, dbg_ack}, 32'd0);
                chk("tail_waddr", {27'd0, rf_waddr}, 32'd3);
            end
        end
        chk("x7_in_rf", rf_mem[7], 32'h0000_0011);

        // Debug read x9 bypassed from the W stage.
        next_cyc();
        wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_1234;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd9;
        next_cyc();
        wb_we = 1'b0; dbg_req = 1'b0;
        #1;
        chk("rd9_ack", {31'd0, dbg_ack}, 32'd1);
        chk("rd9_rdata", dbg_rdata, 32'h0000_1234);

        // Debug read x0 must return zero regardless of the array.
        next_cyc();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd0;
        next_cyc();
        dbg_req = 1'b0;
        #1;
        chk("rd0_ack", {31'd0, dbg_ack}, 32'd1);
        chk("rd0_rdata", dbg_rdata, 32'd0);

        // Debug read x5 from the array.
        next_cyc();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
        next_cyc();
        dbg_req = 1'b0;
        #1;
        chk("rd5_ack", {31'd0, dbg_ack}, 32'd1);
        chk("rd5_rdata", dbg_rdata, 32'hDEAD_BEEF);

        // Debug write to x0 acks without a port write.
        next_cyc();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'hFFFF_FFFF;
        #1;
        chk("w0_we", {31'd0, rf_we}, 32'd0);
        next_cyc();
        dbg_req = 1'b0;
        #1;
        chk("w0_ack", {31'd0, dbg_ack}, 32'd1);
        chk("w0_we_ack", {31'd0, rf_we}, 32'd0);

        // Reset while a debug write is waiting.
        next_cyc();
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h0000_0044;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd12; dbg_wdata = 32'h0000_00CC;
        next_cyc();
        next_cyc();
        chk("wait_ack", {31'd0, dbg_ack}, 32'd0);
        next_cyc();
        rst = 1'b1;
        next_cyc();
        rst = 1'b0; dbg_req = 1'b0; wb_we = 1'b0;
        #1;
        chk("rst2_ack", {31'd0, dbg_ack}, 32'd0);
        chk("rst2_init_done", {31'd0, init_done}, 32'd0);
        chk("rst2_rdata", dbg_rdata, 32'd0);
        chk("rst2_stall", {31'd0, stall_o}, 32'd1);
        chk("rst2_waddr", {27'd0, rf_waddr}, 32'd1);
        next_cyc();
        chk("rst2_waddr2", {27'd0, rf_waddr}, 32'd2);
        chk("rst2_ack2", {31'd0, dbg_ack}, 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/rf_port_sequencer.md
Name: rf_port_sequencer

Overview:
- Sequences and arbitrates the single write port of the decode-stage register file.
- After reset it clears x1..x31 through the write port while stalling the pipeline.
- In normal operation it merges write-back (W stage) writes with debug read/write requests.
- W-stage writes have priority. A starvation guard stalls the pipeline for one cycle to force a pending debug write.

Parameters:
- NUM_REGS, 32, number of architectural registers; x0 is hardwired zero.
- XLEN, 32, data width.
- MAX_WAIT, 8, consecutive blocked cycles before a debug write is forced (1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- wb_we  in  1  W-stage register write enable.
- wb_rd  in  5  W-stage destination register.
- wb_data  in  XLEN  W-stage result.
- dbg_req  in  1  debug request; level, held until dbg_ack.
- dbg_we  in  1  1 = debug write, 0 = debug read; stable while dbg_req=1.
- dbg_addr  in  5  debug register address.
- dbg_wdata  in  XLEN  debug write data.
- dbg_ack  out  1  one-cycle completion pulse; registered.
- dbg_rdata  out  XLEN  read data; valid when dbg_ack=1 for a read; registered.
- rf_dbg_raddr  out  5  register-file debug read address; equals dbg_addr.
- rf_dbg_rdata  in  XLEN  combinational register-file read of rf_dbg_raddr.
- rf_we  out  1  register-file write enable; combinational.
- rf_waddr  out  5  register-file write address; combinational.
- rf_wdata  out  XLEN  register-file write data; combinational.
- stall_o  out  1  freeze all pipeline registers, including MEM/W; combinational from state.
- init_done  out  1  high once the clear sequence has completed; registered.

Behaviour:
- Reset (rst=1 at an edge):
  - state=CLEAR, clr_idx=1, wait_cnt=0.
  - dbg_ack=0, dbg_rdata=0, init_done=0.
  - A reset mid-operation drops any pending debug request; no ack is issued for it.
- wb_valid = wb_we && (wb_rd != 0).
- CLEAR:
  - stall_o=1, rf_we=1, rf_waddr=clr_idx, rf_wdata=0.
  - clr_idx increments each cycle.
  - When clr_idx = NUM_REGS-1 is written, go to IDLE. init_done=1 from the next cycle onward.
  - This takes exactly NUM_REGS-1 (31) cycles.
  - wb inputs and dbg_req are ignored in CLEAR.
- Default in IDLE/WAIT/ACK: rf_we=wb_valid, rf_waddr=wb_rd, rf_wdata=wb_data, stall_o=0.
- IDLE, dbg_req=1, dbg_we=0 (read):
  - Capture dbg_rdata: 0 if dbg_addr=0; else wb_data if wb_valid and wb_rd=dbg_addr (bypass); else rf_dbg_rdata.
  - Go to ACK.
- IDLE/WAIT, dbg_req=1, dbg_we=1 (write):
  - If !wb_valid: rf_we=1, rf_waddr=dbg_addr, rf_wdata=dbg_wdata, then go to ACK.
  - A write to dbg_addr=0 acks with rf_we=0.
  - Otherwise go to / stay in WAIT and increment wait_cnt.
- WAIT with wait_cnt=MAX_WAIT: go to FORCE.
- FORCE (one cycle):
  - stall_o=1; the debug write drives the port; the W-stage write is dropped.
  - Because the pipeline is frozen, the same W write is re-presented and performed in the next cycle. Go to ACK; wait_cnt=0.
- ACK:
  - dbg_ack=1 for exactly one cycle; dbg_req is ignored in this cycle.
  - Return to IDLE; a still-high dbg_req starts a new transaction from IDLE.
- Latency:
  - Read: ack 1 cycle after acceptance.
  - Unblocked write: ack the cycle after the RF write.
  - Worst-case write: ack MAX_WAIT+2 cycles after request.
- Ordering: a debug write and a W write to the same register in different cycles land in port order; the later one wins.

Test Plan:
- Reset then run 40 cycles:
  - stall_o=1 and rf_we=1 for exactly 31 cycles, rf_waddr=1..31 in order, rf_wdata=0.
  - init_done rises the cycle after x31 is written.
  - dbg_req held during CLEAR gets no ack.
- Debug write x5=0xDEADBEEF with wb_we=0:
  - rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in the request cycle.
  - dbg_ack=1 next cycle.
- Debug write x7=0x11 with wb_valid high (wb_rd=3) for 20 cycles, MAX_WAIT=8:
  - FORCE occurs in the 10th cycle: stall_o=1 and rf_waddr=7.
  - Next cycle rf_waddr=3 with wb_data, and dbg_ack=1.
- Debug read x9 while wb_we=1, wb_rd=9, wb_data=0x1234 → dbg_rdata=0x1234 with dbg_ack.
- Debug read x0 → dbg_rdata=0.
- Debug write to x0 → ack with no rf_we.
- Assert rst in WAIT after 3 blocked cycles → no dbg_ack; CLEAR restarts at clr_idx=1; init_done=0.
